row_packet_assembler: RTL
=========================

Name: row_packet_assembler

Overview:
- Sits between the USB byte-stream front end and the LED controller's chunk-write port.
- Parses a framed row packet from an 8-bit valid/ready byte stream: one header byte followed by 64 data bytes.
- Packs the data bytes into sixteen 32-bit chunks, writes them one chunk at a time, and presents the row/panel address of the packet.
- Reports framing errors and stalled-transfer timeouts; exports a one-hot state vector for the status LEDs.

Parameters:
CHUNKS_PER_ROW, 16, chunks per packet; chunk_addr runs 0..CHUNKS_PER_ROW-1 (must be ≤16).
TIMEOUT_CYCLES, 1000000, max clk cycles between accepted bytes in DATA before abort (20 ms at 50 MHz).

Ports:
clk  input  1  system clock, 50 MHz, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
byte_data  input  8  incoming stream byte
byte_valid  input  1  byte_data valid this cycle
byte_ready  output  1  block accepts a byte when byte_valid & byte_ready at a rising edge
chunk_data  output  32  assembled chunk; first byte of the chunk in [31:24], fourth byte in [7:0]
chunk_addr  output  4  chunk index within the row
chunk_write_enable  output  1  one-cycle write strobe
row_addr  output  4  row from the header
panel_addr  output  2  panel from the header
row_done  output  1  one-cycle pulse after the last chunk write
sync_error  output  1  one-cycle pulse: bad header byte dropped
timeout_error  output  1  one-cycle pulse: packet aborted on timeout
error_count  output  8  saturating count of sync and timeout errors
state_out  output  5  one-hot current state

Behaviour:
- Reset values:
  - all outputs 0, except state_out = 5'b00001 (IDLE) and byte_ready = 1.
  - byte counter, chunk counter and timeout counter cleared.
  - Reset asserted mid-packet discards the packet. Chunks already written are not retracted.
- States and encodings: IDLE 00001, DATA 00010, WRITE 00100, DONE 01000, ERROR 10000.
- byte_ready is 1 in IDLE and DATA and 0 in WRITE, DONE and ERROR. It is a registered function of state.
- IDLE, byte accepted:
  - bit7 = 1: latch panel_addr = byte[5:4] and row_addr = byte[3:0]; clear the counters; go to DATA. bit6 is reserved and ignored.
  - bit7 = 0: byte dropped; sync_error pulses the next cycle; error_count increments; stay in IDLE.
- DATA:
  - Each accepted byte is shifted into chunk_data: {chunk_data[23:0], byte}.
  - Byte counter 0..3 advances; the timeout counter is cleared on each accept.
  - On the 4th byte accepted, go to WRITE.
- WRITE (exactly 1 cycle):
  - chunk_write_enable = 1; chunk_data and chunk_addr are stable.
  - The strobe appears the cycle after the 4th byte is accepted.
  - Next state: if chunk_addr == CHUNKS_PER_ROW-1 go to DONE; otherwise chunk_addr increments and the block returns to DATA.
- DONE (1 cycle): row_done = 1; then go to IDLE. row_addr, panel_addr and chunk_data hold until the next header.
- Timeout:
  - In DATA, the timeout counter increments every cycle with no accept.
  - When it reaches TIMEOUT_CYCLES-1 with no accept that cycle: go to ERROR, timeout_error pulses, error_count increments.
  - If a byte is accepted in the expiry cycle, the byte wins and the counter clears.
- ERROR (1 cycle): then go to IDLE; the partial chunk is discarded and chunk_addr is reset to 0.
- error_count saturates at 255. Error pulses are registered (1-cycle latency from the causing edge). They never overlap with chunk_write_enable.
- Minimum packet duration: 65 accepts + 16 WRITE + 1 DONE = 82 cycles.
- The timeout counter needs ceil(log2(TIMEOUT_CYCLES)) bits.

Test Plan:
- Reset → state_out = 00001, byte_ready = 1, error_count = 0. Then send header 0x97 plus bytes 0x00..0x3F with valid held high → panel_addr = 1, row_addr = 7; 16 strobes with chunk_addr 0..15; chunk 0 = 0x00010203, chunk 15 = 0x3C3D3E3F; row_done one cycle after the last strobe; 82 cycles total.
- Send bytes 0x12, 0x05 in IDLE, then header 0x80 → two sync_error pulses, error_count = 2, both bytes dropped; the packet after 0x80 assembles normally with row_addr = 0, panel_addr = 0.
- Header plus 10 data bytes, then valid low → timeout_error exactly TIMEOUT_CYCLES cycles after the last accept (bench with TIMEOUT_CYCLES = 100); back to IDLE; a following full packet starts at chunk_addr 0.
- Random byte_valid gaps (< TIMEOUT_CYCLES) → chunk values are identical to the back-to-back run; byte_ready = 0 only during WRITE/DONE; no byte is lost or duplicated while valid is held across the ready-low cycle.
- Assert reset after chunk 5 is written → all outputs return to reset values within the same cycle, asynchronously; no further strobes.
- Inject 300 bad header bytes → error_count stops at 255.

Source files
------------

// File: rtl/row_packet_assembler.sv
`timescale 1ns/1ps
// Row packet assembler: parses a header byte plus CHUNKS_PER_ROW*4 data bytes from a
// valid/ready byte stream and emits 32-bit chunk writes with row/panel addressing.
module row_packet_assembler #(
  parameter int CHUNKS_PER_ROW = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] chunk_data,
  output logic [3:0]  chunk_addr,
  output logic        chunk_write_enable,
  output logic [3:0]  row_addr,
  output logic [1:0]  panel_addr,
  output logic        row_done,
  output logic        sync_error,
  output logic        timeout_error,
  output logic [7:0]  error_count,
  output logic [4:0]  state_out
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      CHUNK_LAST = 4'(CHUNKS_PER_ROW - 1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_DATA  = 5'b00010,
    S_WRITE = 5'b00100,
    S_DONE  = 5'b01000,
    S_ERROR = 5'b10000
  } state_t;

  state_t          state_q, state_d;
  logic            byte_ready_q, byte_ready_d;
  logic [31:0]     chunk_q, chunk_d;
  logic [3:0]      chunk_addr_q, chunk_addr_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]      row_q, row_d;
  logic [1:0]      panel_q, panel_d;
  logic            sync_err_q, sync_err_d;
  logic            to_err_q, to_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            accept;
  logic            err_inc;

  assign accept = byte_valid & byte_ready_q;

  always_comb begin
    state_d      = state_q;
    chunk_d      = chunk_q;
    chunk_addr_d = chunk_addr_q;
    byte_cnt_d   = byte_cnt_q;
    to_cnt_d     = to_cnt_q;
    row_d        = row_q;
    panel_d      = panel_q;
    sync_err_d   = 1'b0;
    to_err_d     = 1'b0;
    err_inc      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (byte_data[7]) begin
            // bit6 is reserved; a header always restarts addressing from chunk 0
            panel_d      = byte_data[5:4];
            row_d        = byte_data[3:0];
            byte_cnt_d   = 2'd0;
            chunk_addr_d = 4'd0;
            to_cnt_d     = '0;
            state_d      = S_DATA;
          end else begin
            sync_err_d = 1'b1;
            err_inc    = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          chunk_d  = {chunk_q[23:0], byte_data};
          to_cnt_d = '0;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            state_d    = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          to_err_d = 1'b1;
          err_inc  = 1'b1;
          state_d  = S_ERROR;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (chunk_addr_q == CHUNK_LAST) begin
          state_d = S_DONE;
        end else begin
          chunk_addr_d = chunk_addr_q + 4'd1;
          state_d      = S_DATA;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        chunk_addr_d = 4'd0;
        byte_cnt_d   = 2'd0;
        to_cnt_d     = '0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    err_cnt_d    = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    byte_ready_d = (state_d == S_IDLE) || (state_d == S_DATA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_ready_q <= 1'b1;
      chunk_q      <= 32'd0;
      chunk_addr_q <= 4'd0;
      byte_cnt_q   <= 2'd0;
      to_cnt_q     <= '0;
      row_q        <= 4'd0;
      panel_q      <= 2'd0;
      sync_err_q   <= 1'b0;
      to_err_q     <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      chunk_q      <= chunk_d;
      chunk_addr_q <= chunk_addr_d;
      byte_cnt_q   <= byte_cnt_d;
      to_cnt_q     <= to_cnt_d;
      row_q        <= row_d;
      panel_q      <= panel_d;
      sync_err_q   <= sync_err_d;
      to_err_q     <= to_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Strobes decode the one-hot state register directly, so they never overlap
  assign byte_ready         = byte_ready_q;
  assign chunk_data         = chunk_q;
  assign chunk_addr         = chunk_addr_q;
  assign chunk_write_enable = (state_q == S_WRITE);
  assign row_done           = (state_q == S_DONE);
  assign row_addr           = row_q;
  assign panel_addr         = panel_q;
  assign sync_error         = sync_err_q;
  assign timeout_error      = to_err_q;
  assign error_count        = err_cnt_q;
  assign state_out          = state_q;

endmodule
